// File: rtl/vector_instruction_sequencer.sv
// Multi-cycle LOAD/STORE/ADD/MUL controller for the 4 x 512-bit vector datapath.
// Define SEQ_STATS_EN to add the retired_count / mul_count statistics outputs.
module vector_instruction_sequencer #(
  parameter int         MEM_ADDR_W     = 9,
  parameter int         REG_ADDR_W     = 2,
  parameter int         MEM_RD_LATENCY = 1,
  parameter logic [1:0] ALU_OP_ADD     = 2'b00,
  parameter logic [1:0] ALU_OP_MUL     = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_dst,
  input  logic [REG_ADDR_W-1:0] instr_src_a,
  input  logic [REG_ADDR_W-1:0] instr_src_b,
  input  logic [MEM_ADDR_W-1:0] instr_mem_addr,
  output logic [REG_ADDR_W-1:0] rf_read_a_addr,
  output logic [REG_ADDR_W-1:0] rf_read_b_addr,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic                  rf_write_en,
  output logic [1:0]            rf_write_sel,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [1:0]            alu_opcode,
  output logic                  alu_capture,
  output logic                  busy,
  output logic                  done
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]           retired_count,
  output logic [15:0]           mul_count
`endif
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b11;
  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEM_RD = 3'd1,
    S_MEM_WR = 3'd2,
    S_EXEC   = 3'd3,
    S_WB_LO  = 3'd4,
    S_WB_HI  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [1:0]              op_r;
  logic [REG_ADDR_W-1:0]   dst_r, src_a_r, src_b_r;
  logic [MEM_ADDR_W-1:0]   mem_addr_r;
  logic [1:0]              alu_op_r;
  logic [2:0]              lat_cnt_r;
  logic                    accept_s;
  logic                    wen_s, mwe_s, cap_s, done_s;
  logic [1:0]              sel_s;
  logic [REG_ADDR_W-1:0]   waddr_s;

  assign instr_ready = (state_r == S_IDLE) && !rst;
  assign accept_s    = instr_valid && instr_ready;

  // State register, latched instruction fields and memory read wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      op_r       <= 2'b00;
      dst_r      <= '0;
      src_a_r    <= '0;
      src_b_r    <= '0;
      mem_addr_r <= '0;
      alu_op_r   <= 2'b00;
      lat_cnt_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_r       <= instr_op;
        dst_r      <= instr_dst;
        src_a_r    <= instr_src_a;
        src_b_r    <= instr_src_b;
        mem_addr_r <= instr_mem_addr;
        lat_cnt_r  <= 3'd0;
        // alu_opcode only moves for ALU instructions and otherwise holds
        if (instr_op == OP_MUL) alu_op_r <= ALU_OP_MUL;
        else if (instr_op != OP_LOAD && instr_op != OP_STORE) alu_op_r <= ALU_OP_ADD;
        else alu_op_r <= alu_op_r;
      end else if (state_r == S_MEM_RD) begin
        lat_cnt_r <= lat_cnt_r + 3'd1;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
    end
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_nxt_s = state_r;
    wen_s       = 1'b0;
    mwe_s       = 1'b0;
    cap_s       = 1'b0;
    done_s      = 1'b0;
    sel_s       = 2'b00;
    waddr_s     = dst_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (instr_op)
            OP_LOAD:  state_nxt_s = S_MEM_RD;
            OP_STORE: state_nxt_s = S_MEM_WR;
            default:  state_nxt_s = S_EXEC;
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MEM_RD: begin
        if (lat_cnt_r == LAT_LAST) state_nxt_s = S_WB_LO;
        else state_nxt_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        mwe_s       = 1'b1;
        state_nxt_s = S_DONE;
      end
      S_EXEC: begin
        cap_s       = 1'b1;
        state_nxt_s = S_WB_LO;
      end
      S_WB_LO: begin
        wen_s       = 1'b1;
        sel_s       = (op_r == OP_LOAD) ? 2'b00 : 2'b01;
        state_nxt_s = (op_r == OP_MUL) ? S_WB_HI : S_DONE;
      end
      S_WB_HI: begin
        wen_s       = 1'b1;
        sel_s       = 2'b10;
        waddr_s     = dst_r + REG_ADDR_W'(1);
        state_nxt_s = S_DONE;
      end
      S_DONE: begin
        done_s      = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Strobes are suppressed while rst is high so an aborted instruction writes nothing
  assign rf_write_en    = wen_s & ~rst;
  assign mem_write_en   = mwe_s & ~rst;
  assign alu_capture    = cap_s & ~rst;
  assign done           = done_s & ~rst;
  assign rf_write_sel   = sel_s;
  assign rf_write_addr  = waddr_s;
  assign rf_read_a_addr = src_a_r;
  assign rf_read_b_addr = src_b_r;
  assign mem_addr       = mem_addr_r;
  assign alu_opcode     = alu_op_r;
  assign busy           = (state_r != S_IDLE);

`ifdef SEQ_STATS_EN
  // Retirement statistics, both counters wrap at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= 16'd0;
      mul_count     <= 16'd0;
    end else if (state_r == S_DONE) begin
      retired_count <= retired_count + 16'd1;
      if (op_r == OP_MUL) mul_count <= mul_count + 16'd1;
      else mul_count <= mul_count;
    end else begin
      retired_count <= retired_count;
      mul_count     <= mul_count;
    end
  end
`endif

endmodule
